// File: rtl/fusion_pkg.sv
// Shared definitions for the fusion adder: lane-width encoding and the
// carry-cut rule used by every slice.
package fusion_pkg;

    localparam int BRICK_W = 2;

    typedef enum logic [1:0] {
        MODE_2B   = 2'd0,
        MODE_4B   = 2'd1,
        MODE_8B   = 2'd2,
        MODE_FULL = 2'd3
    } mode_e;

    // True when the lane ends after brick brick_idx; width is the full word width.
    function automatic logic lane_boundary(input int brick_idx, input mode_e mode, input int width);
        int lane_w;
        case (mode)
            MODE_2B: lane_w = 2;
            MODE_4B: lane_w = 4;
            MODE_8B: lane_w = 8;
            default: lane_w = width;
        endcase
        return (((brick_idx + 1) * BRICK_W) % lane_w) == 0;
    endfunction

endpackage

// File: rtl/fusion_adder_brick_slice.sv
// Combinational SW-bit ripple adder made of full-adder cells, with the carry
// chain cut (and re-seeded by cin) at every lane boundary.
module brick_slice
    import fusion_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SW    = 8,
    parameter int OFF_W = 3
) (
    input  logic [SW-1:0]         a,
    input  logic [SW-1:0]         b,
    input  logic                  carry_in,
    input  logic                  cin,
    input  mode_e                 mode,
    input  logic [OFF_W-1:0]      offset,
    output logic [SW-1:0]         sum,
    output logic [SW/BRICK_W-1:0] cout,
    output logic                  carry_out
);

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    int         base;
    logic       c;
    logic [1:0] fa;

    always_comb begin
        sum  = '0;
        cout = '0;
        fa   = '0;
        base = int'(offset);
        // A lane ending just below this slice means the registered carry is not ours.
        c = (offset == '0 || lane_boundary(base - 1, mode, WIDTH)) ? cin : carry_in;
        for (int i = 0; i < SW; i++) begin
            if ((i % BRICK_W) == 0 && i > 0 && lane_boundary(base + i / BRICK_W - 1, mode, WIDTH)) begin
                c = cin;
            end
            fa     = full_add(a[i], b[i], c);
            sum[i] = fa[0];
            c      = fa[1];
            if ((i % BRICK_W) == BRICK_W - 1 && lane_boundary(base + i / BRICK_W, mode, WIDTH)) begin
                cout[i / BRICK_W] = c;
            end
        end
        carry_out = c;
    end

endmodule

// File: rtl/fusion_adder.sv
// Pipelined lane-configurable adder: STAGES registered slices, each adding
// WIDTH/STAGES bits, with a single global advance enable for backpressure.
module fusion_adder
    import fusion_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   sum,
    output logic [WIDTH/2-1:0] cout
);

    localparam int SW    = WIDTH / STAGES;
    localparam int SB    = SW / BRICK_W;
    localparam int NB    = WIDTH / BRICK_W;
    localparam int OFF_W = $clog2(NB);

    logic             vld_q   [STAGES];
    logic             vld_d   [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic [NB-1:0]    cout_q  [STAGES];
    logic [NB-1:0]    cout_d  [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic             cin_q   [STAGES];
    logic             cin_d   [STAGES];
    mode_e            mode_q  [STAGES];
    mode_e            mode_d  [STAGES];

    logic             src_vld   [STAGES];
    logic             src_carry [STAGES];
    logic [WIDTH-1:0] src_sum   [STAGES];
    logic [NB-1:0]    src_cout  [STAGES];
    logic [WIDTH-1:0] src_a     [STAGES];
    logic [WIDTH-1:0] src_b     [STAGES];
    logic             src_cin   [STAGES];
    mode_e            src_mode  [STAGES];

    logic [SW-1:0]    sl_sum   [STAGES];
    logic [SB-1:0]    sl_cout  [STAGES];
    logic             sl_carry [STAGES];

    logic adv;
    int   prev;

    assign adv       = !vld_q[STAGES-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = cout_q[STAGES-1];

    // Stage k consumes the input ports (k = 0) or the registers of stage k-1.
    always_comb begin
        prev = 0;
        for (int k = 0; k < STAGES; k++) begin
            prev = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                src_vld[k]   = in_valid;
                src_carry[k] = cin;
                src_sum[k]   = '0;
                src_cout[k]  = '0;
                src_a[k]     = a;
                src_b[k]     = b;
                src_cin[k]   = cin;
                src_mode[k]  = mode_e'(mode);
            end else begin
                src_vld[k]   = vld_q[prev];
                src_carry[k] = carry_q[prev];
                src_sum[k]   = sum_q[prev];
                src_cout[k]  = cout_q[prev];
                src_a[k]     = a_q[prev];
                src_b[k]     = b_q[prev];
                src_cin[k]   = cin_q[prev];
                src_mode[k]  = mode_q[prev];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        brick_slice #(
            .WIDTH (WIDTH),
            .SW    (SW),
            .OFF_W (OFF_W)
        ) u_slice (
            .a         (src_a[k][k*SW +: SW]),
            .b         (src_b[k][k*SW +: SW]),
            .carry_in  (src_carry[k]),
            .cin       (src_cin[k]),
            .mode      (src_mode[k]),
            .offset    (OFF_W'(k * SB)),
            .sum       (sl_sum[k]),
            .cout      (sl_cout[k]),
            .carry_out (sl_carry[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            vld_d[k]   = vld_q[k];
            carry_d[k] = carry_q[k];
            sum_d[k]   = sum_q[k];
            cout_d[k]  = cout_q[k];
            a_d[k]     = a_q[k];
            b_d[k]     = b_q[k];
            cin_d[k]   = cin_q[k];
            mode_d[k]  = mode_q[k];
            if (adv) begin
                vld_d[k]               = src_vld[k];
                carry_d[k]             = sl_carry[k];
                sum_d[k]               = src_sum[k];
                sum_d[k][k*SW +: SW]   = sl_sum[k];
                cout_d[k]              = src_cout[k];
                cout_d[k][k*SB +: SB]  = sl_cout[k];
                a_d[k]                 = src_a[k];
                b_d[k]                 = src_b[k];
                cin_d[k]               = src_cin[k];
                mode_d[k]              = src_mode[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k]   <= 1'b0;
                carry_q[k] <= 1'b0;
                sum_q[k]   <= '0;
                cout_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k]   <= vld_d[k];
                carry_q[k] <= carry_d[k];
                sum_q[k]   <= sum_d[k];
                cout_q[k]  <= cout_d[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            a_q[k]    <= a_d[k];
            b_q[k]    <= b_d[k];
            cin_q[k]  <= cin_d[k];
            mode_q[k] <= mode_d[k];
        end
    end

endmodule

// File: doc/fusion_adder.md
# fusion_adder

Pipelined, precision-configurable adder for the fusion datapath. It adds two WIDTH-bit operands as a set of independent lanes whose width (2, 4, 8 or WIDTH bits) is chosen per transaction. Carries are cut at lane boundaries, and the carry chain is split across STAGES registered slices. It sits after the bit-brick multiplier array and accumulates fused partial results, with a valid/ready stream on both sides.

## Interface
- WIDTH, 16: operand and sum width. Must be a power of two, at least 8.
- STAGES, 2: pipeline slices. WIDTH/STAGES must be a multiple of 2.
- clk  in  1: clock. All logic updates on the rising edge.
- rst  in  1: reset, synchronous and active-high.
- in_valid  in  1: operand beat valid.
- in_ready  out  1: block accepts a beat this cycle.
- a, b  in  WIDTH: operands.
- cin  in  1: carry-in, applied to the LSB of every lane.
- mode  in  2: lane width. 0 = 2-bit, 1 = 4-bit, 2 = 8-bit, 3 = WIDTH-bit.
- out_valid  out  1: result valid.
- out_ready  in  1: downstream accepts the result.
- sum  out  WIDTH: lane-wise sum, lane i in its own bit field.
- cout  out  WIDTH/2: per-brick carry-out. Bit j is the carry out of brick j (bits 2j+1:2j) only if brick j is a lane MSB; otherwise 0.

## Operation
- Bricks are 2 bits wide. A lane boundary sits after brick j when (j+1)·2 is a multiple of the lane width.
- At every lane boundary, the carry into the next brick is cin, not the propagated carry.
- Slice k (0..STAGES-1) computes bits [k·SW +: SW], where SW = WIDTH/STAGES.
- Slice k uses the carry registered from slice k-1. If a lane boundary falls on the slice boundary, it uses cin instead. Slice 0 uses cin.
- The unprocessed operand bits, mode, cin and the finished sum and cout bits travel with the beat through per-stage registers.
- A mode change between consecutive beats is legal. Each beat uses only its own registered mode; beats never mix.
- Arithmetic is modulo 2^lane-width per lane. The sign/unsigned interpretation is the consumer's; this block reports raw carries only.

## Timing
- Latency: exactly STAGES cycles from the in_valid && in_ready edge to out_valid, when there is no backpressure.
- Throughput: one beat per cycle.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv.
- When adv = 0, every stage register holds, including valid bits and data.
- Bubbles are not compressed. Stage valid bits shift with adv.
- A beat is accepted only on in_valid && in_ready. With in_valid = 0, a bubble (valid = 0) enters stage 0.
- Simultaneous out_valid && out_ready and in_valid: the output retires and a new beat enters in the same cycle.
- Reset clears all stage valid bits and carry registers, and sum/cout to 0. During and after reset: out_valid = 0, sum = 0, cout = 0, and in_ready = 1.
- Reset mid-operation drops all in-flight beats. The first output after reset comes from a beat accepted after reset.
- Data registers need not be cleared except for the output registers.

## Structure
- Shared package `fusion_pkg` holds:
  - the mode encoding (MODE_2B, MODE_4B, MODE_8B, MODE_FULL) as an enum;
  - BRICK_W = 2;
  - a function `lane_boundary(brick_idx, mode)` returning 1 when a carry cut follows the brick.
- Sub-module `brick_slice` is a combinational SW-bit adder built from full-adder cells.
  - Inputs: slice operands, carry-in, cin, mode, and slice offset.
  - Outputs: the slice sum, its cout bits, and the carry-out to the next slice.
  - Carries are cut via `lane_boundary`.
- The top level instantiates STAGES slices plus the stage registers and handshake.

## Test plan
All cases use WIDTH=16, STAGES=2.
- **2-bit lanes:** mode 0, a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'hFFFC, cout=8'h01, out_valid 2 cycles after acceptance.
- **Full width:** mode 3, a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=8'h80. Also a=16'h00FF, b=16'h0001 -> sum=16'h0100, cout=8'h00, which checks the carry across the slice boundary.
- **8-bit lanes with cin:** mode 2, a=16'h00FF, b=16'h0001, cin=0 -> sum=16'h0000, cout=8'h08. With a=16'h7F7F, b=16'h0101, cin=1 -> sum=16'h8181, cout=8'h00.
- **Mode change:** back-to-back beats with modes 0, 3, 1, 2 on random operands -> each result matches a per-lane reference model, in order, one per cycle.
- **Backpressure:** hold out_ready=0 for 5 cycles with a continuous input stream -> in_ready drops once out_valid=1, sum and cout stay stable, no beat is lost or duplicated after release.
- **Reset mid-operation:** assert rst for 1 cycle with 2 beats in flight -> the next cycle shows out_valid=0, sum=0, cout=0, in_ready=1, and no stale beat appears afterwards.
